// File: rtl/tx_frame_arb.sv
// tx_frame_arb
// Round-robin arbiter that hands a shared UART transmitter to one of NREQ
// frame requesters at a time. It issues the start pulse and watches the
// core's busy flag. Each frame ends with a done pulse. Every frame is
// followed by an enforced idle gap.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   req        : per-requester single-cycle frame request pulse
//   err_clr    : single-cycle pulse clearing every err bit
//   tx_busy    : UART core transmitting
//   tx_trigger : single-cycle start pulse to the UART core
//   tx_sel     : index of the granted requester (frame mux select)
//   done       : single-cycle completion pulse per requester
//   err        : sticky start-timeout flag per requester
//   pending    : latched outstanding requests
//   active     : high whenever the arbiter is not idle
module tx_frame_arb #(
    parameter int NREQ          = 3,
    parameter int GAP_CYCLES    = 1000,
    parameter int START_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            err_clr,
    input  logic            tx_busy,
    output logic            tx_trigger,
    output logic [1:0]      tx_sel,
    output logic [NREQ-1:0] done,
    output logic [NREQ-1:0] err,
    output logic [NREQ-1:0] pending,
    output logic            active
);

    // One timer serves both the start timeout and the gap, so size it for the larger.
    localparam int MAXV     = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
    localparam int TW       = $clog2(MAXV + 1);
    localparam int ST_LAST  = START_TIMEOUT - 1;
    // A zero-length gap still spends one clock in GAP.
    localparam int GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_e;

    state_e          state_q;
    logic [TW-1:0]   timer_q;
    logic [1:0]      last_sel_q;
    logic [1:0]      tx_sel_q;
    logic            tx_trigger_q;
    logic            active_q;
    logic [NREQ-1:0] done_q;
    logic [NREQ-1:0] err_q;
    logic [NREQ-1:0] pending_q;

    logic [NREQ-1:0] pending_d;
    logic [NREQ-1:0] err_d;
    logic [NREQ-1:0] sel_mask_s;
    logic [NREQ-1:0] clr_mask_s;
    logic [NREQ-1:0] err_set_s;
    logic            timeout_s;
    logic [1:0]      grant_s;
    logic            found_s;

    // Round-robin search starting one past the last granted index.
    always_comb begin
        grant_s = last_sel_q;
        found_s = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_sel_q) + k) % NREQ;
            if (!found_s && ((pending_q & (ONE_HOT0 << idx)) != '0)) begin
                found_s = 1'b1;
                grant_s = 2'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pending and err next-state.
    // A new request beats the TRIG-clock clear, and a timeout set beats err_clr.
    always_comb begin
        sel_mask_s = ONE_HOT0 << tx_sel_q;
        timeout_s  = (state_q == WAIT_BUSY) && !tx_busy && (timer_q == TW'(ST_LAST));
        if (state_q == TRIG) begin
            clr_mask_s = sel_mask_s;
        end else begin
            clr_mask_s = '0;
        end
        if (timeout_s) begin
            err_set_s = sel_mask_s;
        end else begin
            err_set_s = '0;
        end
        pending_d = (pending_q & ~clr_mask_s) | req;
        err_d     = (err_q & ~{NREQ{err_clr}}) | err_set_s;
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            last_sel_q   <= 2'(NREQ - 1);
            tx_sel_q     <= 2'd0;
            tx_trigger_q <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= '0;
            err_q        <= '0;
            pending_q    <= '0;
        end else begin
            tx_trigger_q <= 1'b0;
            done_q       <= '0;
            pending_q    <= pending_d;
            err_q        <= err_d;
            case (state_q)
                IDLE: begin
                    if (found_s) begin
                        tx_sel_q     <= grant_s;
                        last_sel_q   <= grant_s;
                        tx_trigger_q <= 1'b1;
                        active_q     <= 1'b1;
                        state_q      <= TRIG;
                    end else begin
                        active_q <= 1'b0;
                    end
                end
                TRIG: begin
                    timer_q <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (timeout_s) begin
                        done_q  <= sel_mask_s;
                        timer_q <= '0;
                        state_q <= GAP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        done_q  <= sel_mask_s;
                        timer_q <= '0;
                        state_q <= GAP;
                    end else begin
                        state_q <= WAIT_DONE;
                    end
                end
                GAP: begin
                    if (timer_q == TW'(GAP_LAST)) begin
                        timer_q  <= '0;
                        active_q <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    timer_q  <= '0;
                    active_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign tx_trigger = tx_trigger_q;
    assign tx_sel     = tx_sel_q;
    assign done       = done_q;
    assign err        = err_q;
    assign pending    = pending_q;
    assign active     = active_q;

endmodule

// File: doc/tx_frame_arb.md
TX_FRAME_ARB -- requirements
Module: tx_frame_arb

Interface
REQ-001 Parameter: NREQ, 3, number of frame requesters (2..4).
REQ-002 Parameter: GAP_CYCLES, 1000, idle clocks enforced between frames (0 allowed).
REQ-003 Parameter: START_TIMEOUT, 16, clocks allowed for the UART core to raise tx_busy after a trigger (>=2).
REQ-004 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: req  input  NREQ  per-requester single-cycle frame request pulse.
REQ-007 Port: err_clr  input  1  single-cycle pulse; clears all err bits.
REQ-008 Port: tx_busy  input  1  UART core transmitting, from the UART core.
REQ-009 Port: tx_trigger  output  1  single-cycle start pulse to the UART core.
REQ-010 Port: tx_sel  output  2  index of the granted requester; drives the frame mux feeding tx_in.
REQ-011 Port: done  output  NREQ  single-cycle completion pulse, one bit per requester.
REQ-012 Port: err  output  NREQ  sticky start-timeout flag per requester.
REQ-013 Port: pending  output  NREQ  latched outstanding requests.
REQ-014 Port: active  output  1  high in any state other than IDLE.

Function
REQ-015 req[i] high for one clock SHALL set pending[i]; a req[i] while pending[i] is already set SHALL merge into it (no queueing depth >1).
REQ-016 FSM states: IDLE, TRIG, WAIT_BUSY, WAIT_DONE, GAP.
REQ-017 IDLE: if pending != 0, grant by round-robin starting at (last_sel+1) mod NREQ; latch tx_sel and last_sel; go TRIG next clock.
REQ-018 TRIG: tx_trigger=1 for exactly this clock; pending[tx_sel] cleared this clock; go WAIT_BUSY with timer=0.
REQ-019 Set-over-clear: req[tx_sel] in the TRIG clock SHALL leave pending[tx_sel]=1; requests during an in-flight frame SHALL re-set pending.
REQ-020 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; else if timer==START_TIMEOUT-1 -> set err[tx_sel], pulse done[tx_sel], go GAP; else timer+1.
REQ-021 WAIT_DONE: on the first clock tx_busy=0, pulse done[tx_sel] and go GAP with timer=0; no timeout in this state.
REQ-022 GAP: count GAP_CYCLES clocks, then IDLE; with GAP_CYCLES=0, GAP SHALL last one clock.
REQ-023 tx_sel SHALL hold stable from TRIG through the end of GAP.
REQ-024 err_clr and a simultaneous err set for the same bit: set SHALL win.
REQ-025 Timer SHALL be wide enough for max(GAP_CYCLES, START_TIMEOUT) with no wrap.
REQ-026 Worst-case start latency from req to tx_trigger: 2 clocks when IDLE and no other pending.

Reset
REQ-027 Reset low SHALL asynchronously force: state IDLE, pending=0, err=0, done=0, tx_trigger=0, tx_sel=0, last_sel=NREQ-1, timer=0, active=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no done pulse; the first grant after release SHALL go to the lowest pending index.

Verification
REQ-029 req=3'b001 in IDLE, tx_busy high 2 clocks after trigger for 50 clocks -> tx_trigger pulse at clock+2, tx_sel=0, done[0] one clock after tx_busy falls, next trigger >= GAP_CYCLES later.
REQ-030 req=3'b111 in one clock -> grants in order 0,1,2 with three done pulses; then req=3'b101 -> grants in order 0,2.
REQ-031 req[1] with tx_busy held 0 -> err[1]=1 and done[1] START_TIMEOUT clocks after WAIT_BUSY entry; err_clr -> err=0.
REQ-032 req[0] pulsed in the TRIG clock of requester 0 and again during WAIT_DONE -> exactly one further frame for requester 0.
REQ-033 Reset pulled low during WAIT_DONE -> all outputs 0 immediately, no done; after release req=3'b110 -> tx_sel=1 first.
REQ-034 GAP_CYCLES=0 build, req=3'b011 -> consecutive triggers separated only by WAIT_DONE exit plus one GAP clock plus IDLE.
